// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: state encodings and
// the default word width.
package shift_seq_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/shift_bit_counter.sv
// Bit-position counter for the serial stream. Counts SHIFT cycles and flags
// the final bit position (WIDTH-1). It holds at terminal count rather than
// wrapping, so a word never sees the count roll back to 0.
module shift_bit_counter
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc = (cnt_q == CNT_W'(WIDTH - 1));

  // Next count: clear wins over enable; saturate at the last bit position.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_register_sequencer.sv
// Sequencer for an external WIDTH-bit parallel-load / serial-shift register.
// Accepts a word, loads it into the register, then streams it LSB-first from
// the register's bit-0 output with valid/last framing and abort support.
//
// Handshake: a word transfers on any rising edge where req_valid and
// req_ready are both high. req_ready is registered and only high in IDLE, so
// req_valid outside IDLE has no effect. The serial side has no ready: the
// register shifts every clock and the consumer must take every valid bit.
module shift_register_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_fill,
  input  logic             abort,
  input  logic             sr_q0,
  output logic [WIDTH-1:0] sr_R,
  output logic             sr_L,
  output logic             sr_w,
  output logic             ser_valid,
  output logic             ser_bit,
  output logic             ser_last,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sr_r_q;
  logic [WIDTH-1:0] sr_r_d;
  logic             fill_q;
  logic             fill_d;
  logic             req_ready_q;
  logic             req_ready_d;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;

  // Counter clears on accept and again on the way back to IDLE so an aborted
  // word leaves no stale position behind.
  assign cnt_clr = accept || (state_q == ST_DONE);
  assign cnt_en  = (state_q == ST_SHIFT);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (cnt_tc)
  );

  // Next-state, capture and ready logic. abort with the last bit still ends
  // in DONE, so it needs no special case.
  always_comb begin
    state_d = state_q;
    sr_r_d  = sr_r_q;
    fill_d  = fill_q;
    accept  = req_valid && req_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          sr_r_d  = req_data;
          fill_d  = req_fill;
        end
      end
      ST_LOAD:  state_d = abort ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (abort || cnt_tc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  // FSM state, captured word, fill bit and registered ready.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      sr_r_q      <= '0;
      fill_q      <= 1'b0;
      req_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_r_q      <= sr_r_d;
      fill_q      <= fill_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Outputs decode from registered state only. sr_w carries the fill bit at
  // all times so the register keeps filling with it after the word drains.
  assign req_ready = req_ready_q;
  assign sr_R      = sr_r_q;
  assign sr_L      = (state_q == ST_LOAD);
  assign sr_w      = fill_q;
  assign ser_valid = (state_q == ST_SHIFT);
  assign ser_bit   = ser_valid && sr_q0;
  assign ser_last  = ser_valid && cnt_tc;
  assign done      = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_register_sequencer.sv
// Testbench for shift_register_sequencer with an external 4-bit shift
// register model feeding sr_q0 and a scoreboard of expected {last, bit} pairs.
module tb_shift_register_sequencer;
  import shift_seq_pkg::*;

  localparam int W = 4;

  logic         Clock;
  logic         Resetn;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_data;
  logic         req_fill;
  logic         abort;
  logic         sr_q0;
  logic [W-1:0] sr_R;
  logic         sr_L;
  logic         sr_w;
  logic         ser_valid;
  logic         ser_bit;
  logic         ser_last;
  logic         done;
  logic         busy;
  logic [1:0]   dbg_state;

  logic [W-1:0] ext_q = '0;
  logic [1:0]   exp_q[$];
  logic [1:0]   exp_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;

  shift_register_sequencer #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_fill  (req_fill),
    .abort     (abort),
    .sr_q0     (sr_q0),
    .sr_R      (sr_R),
    .sr_L      (sr_L),
    .sr_w      (sr_w),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_last  (ser_last),
    .done      (done),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  // External parallel-load / serial-shift register, shifting toward bit 0.
  always @(posedge Clock) begin
    if (sr_L) ext_q <= sr_R;
    else      ext_q <= {sr_w, ext_q[W-1:1]};
  end
  assign sr_q0 = ext_q[0];

  // Scoreboard: every valid serial bit must match the head of the queue.
  always @(negedge Clock) begin
    if (Resetn && ser_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_unexpected got last=%0b bit=%0b exp nothing", ser_last, ser_bit);
      end else begin
        exp_e = exp_q.pop_front();
        if ({ser_last, ser_bit} !== exp_e) begin
          errors++;
          $display("FAIL stream_bit got last=%0b bit=%0b exp last=%0b bit=%0b",
                   ser_last, ser_bit, exp_e[1], exp_e[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Driver: offer a word (called #1 after an edge), return #1 after the
  // accepting edge, i.e. in the LOAD cycle.
  task automatic drive_word(input logic [W-1:0] data, input logic fill);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_data  = data;
    req_fill  = fill;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout got req_ready=%0b exp 1", req_ready);
    end
    @(posedge Clock);
    for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), data[i]});
    #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #2;
    checks++;
    if ({busy, ser_valid, ser_last, done, req_ready, sr_L, sr_w, sr_R, dbg_state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%0b sv=%0b sl=%0b done=%0b rdy=%0b L=%0b w=%0b R=%0h st=%0d exp all 0",
               busy, ser_valid, ser_last, done, req_ready, sr_L, sr_w, sr_R, dbg_state);
    end
    Resetn = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got req_ready=%0b busy=%0b exp 1 0", req_ready, busy);
    end
  endtask

  task automatic test_basic();
    drive_word(4'b1011, 1'b0);
    checks++;
    if (sr_L !== 1'b1 || ser_valid !== 1'b0 || sr_R !== 4'b1011 || dbg_state !== ST_LOAD) begin
      errors++;
      $display("FAIL basic_load got L=%0b sv=%0b R=%0h st=%0d exp 1 0 b 1", sr_L, ser_valid, sr_R, dbg_state);
    end
    for (int k = 0; k < W; k++) begin
      step();
      checks++;
      if (ser_valid !== 1'b1 || sr_L !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL basic_shift k=%0d got sv=%0b L=%0b busy=%0b exp 1 0 1", k, ser_valid, sr_L, busy);
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done got done=%0b sv=%0b rdy=%0b busy=%0b exp 1 0 0 1", done, ser_valid, req_ready, busy);
    end
    step();
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_idle got done=%0b rdy=%0b busy=%0b left=%0d exp 0 1 0 0", done, req_ready, busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    int n;
    n = 0;
    req_valid = 1'b1;
    req_data  = 4'hA;
    req_fill  = 1'b0;
    while (!req_ready && n < 50) begin step(); n++; end
    t1 = cyc;
    for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), req_data[i]});
    step();
    req_data = 4'h5;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    t2 = cyc;
    for (int i = 0; i < W; i++) exp_q.push_back({(i == W - 1), req_data[i]});
    step();
    req_valid = 1'b0;
    checks++;
    if (t2 - t1 != W + 3) begin
      errors++;
      $display("FAIL b2b_interval got %0d exp %0d", t2 - t1, W + 3);
    end
    repeat (W + 3) step();
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got left=%0d busy=%0b exp 0 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_abort();
    drive_word(4'hF, 1'b0);
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (ser_valid !== 1'b0 || done !== 1'b1 || ser_last !== 1'b0) begin
      errors++;
      $display("FAIL abort_done got sv=%0b done=%0b last=%0b exp 0 1 0", ser_valid, done, ser_last);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE || exp_q.size() != 2) begin
      errors++;
      $display("FAIL abort_idle got done=%0b busy=%0b st=%0d left=%0d exp 0 0 0 2", done, busy, dbg_state, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_fill();
    drive_word(4'h0, 1'b1);
    for (int k = 0; k < W; k++) begin
      step();
      checks++;
      if (sr_w !== 1'b1 || ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL fill_sr_w k=%0d got w=%0b sv=%0b exp 1 1", k, sr_w, ser_valid);
      end
    end
    step();
    checks++;
    if (ext_q !== 4'hF || done !== 1'b1) begin
      errors++;
      $display("FAIL fill_register got reg=%0h done=%0b exp f 1", ext_q, done);
    end
    step();
  endtask

  task automatic test_ignore();
    drive_word(4'h3, 1'b0);
    step();
    step();
    req_valid = 1'b1;
    req_data  = 4'hC;
    step();
    step();
    step();
    checks++;
    if (req_ready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done got rdy=%0b done=%0b exp 0 1", req_ready, done);
    end
    step();
    req_valid = 1'b0;
    checks++;
    if (sr_R !== 4'h3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_capture got R=%0h busy=%0b exp 3 0", sr_R, busy);
    end
    step();
    step();
    checks++;
    if (sr_R !== 4'h3 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_after got R=%0h busy=%0b left=%0d exp 3 0 0", sr_R, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    drive_word(4'h6, 1'b0);
    step();
    #1;
    Resetn = 1'b0;
    #1;
    checks++;
    if ({busy, ser_valid, req_ready, sr_L, done, sr_R} !== '0) begin
      errors++;
      $display("FAIL reset_mid got busy=%0b sv=%0b rdy=%0b L=%0b done=%0b R=%0h exp all 0",
               busy, ser_valid, req_ready, sr_L, done, sr_R);
    end
    exp_q.delete();
    step();
    Resetn = 1'b1;
    step();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got rdy=%0b busy=%0b exp 1 0", req_ready, busy);
    end
  endtask

  initial begin
    Resetn    = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_fill  = 1'b0;
    abort     = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort();
    test_fill();
    test_ignore();
    test_reset_mid();
    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shift_register_sequencer.md
Name: shift_register_sequencer

Overview:
Controller that sequences a WIDTH-bit parallel-load/serial-shift register (load mux plus DFF per stage, shifting toward bit 0). It accepts a parallel word over a valid/ready handshake and drives the register's parallel data, load-select and serial-in lines. It then streams the word out LSB-first, one bit per clock, from the register's bit-0 output, with valid/last framing and abort support. It sits between a word producer and a serial consumer; the shift register itself stays external.

Parameters:
WIDTH, 4, number of register stages / bits per word (legal range 2..32)
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden)

Ports:
Clock  input  1  rising-edge clock, shared with the shift register
Resetn  input  1  asynchronous active-low reset
req_valid  input  1  producer presents a word
req_ready  output  1  sequencer can accept a word
req_data  input  WIDTH  word to serialise
req_fill  input  1  serial-in fill bit for this word, captured with req_data
abort  input  1  cancel the word in flight
sr_q0  input  1  bit-0 (Q[0]) output of the shift register
sr_R  output  WIDTH  parallel-load data to the register (R)
sr_L  output  1  load select to the register (1 = load R, 0 = shift)
sr_w  output  1  serial-in to the register's top stage
ser_valid  output  1  ser_bit is a valid data bit this cycle
ser_bit  output  1  serial data, LSB first
ser_last  output  1  marks the final bit of the word
done  output  1  one-cycle pulse after a word completes or is aborted
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, Resetn=0) forces state IDLE, counter 0, sr_R=0, fill reg 0, sr_L=0, sr_w=0, ser_valid=0, ser_last=0, done=0, busy=0, req_ready=0. req_ready rises in the first IDLE cycle after release.
- All outputs are registered or decoded from state only; there are no combinational paths from req_valid or abort to any output.
- States: IDLE, LOAD, SHIFT, DONE. Encodings come from the package.
- IDLE: req_ready=1. On req_valid&&req_ready at edge t, capture req_data into sr_R and req_fill into the fill reg, clear the counter, and move to LOAD.
- LOAD (cycle t+1): sr_L=1 and sr_R is stable. The register loads at the end of this cycle. Next state is SHIFT.
- SHIFT: sr_L=0, sr_w=fill reg, ser_valid=1, ser_bit=sr_q0. The counter k runs 0..WIDTH-1, and bit k of the word appears at cycle t+2+k. ser_last=1 when k=WIDTH-1; that cycle moves to DONE. The counter increments every SHIFT cycle and never wraps inside a word.
- DONE: done=1 for one cycle, ser_valid=0, req_ready=0. Next state is IDLE. Back-to-back word interval is WIDTH+3 cycles.
- There is no backpressure on the serial side: the register shifts every clock, so the consumer must always accept.
- abort, sampled in LOAD or SHIFT: the next state is DONE (done pulses). ser_valid=0 from the cycle after abort is sampled. The counter resets on the return to IDLE. abort is ignored in IDLE and DONE.
- abort asserted together with ser_last: the word counts as complete, and DONE is entered either way.
- req_valid outside IDLE is ignored, since req_ready=0.
- sr_R holds the last captured word until the next accept. It is not cleared on abort.
- Reset mid-word: everything returns to reset values immediately. The register contents are don't-care to this block.

Decomposition:
- Package shift_seq_pkg holds:
  - state encoding constants (ST_IDLE=2'd0, ST_LOAD=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3);
  - WIDTH default.
- One natural sub-module, shift_bit_counter: CNT_W up-counter with sync clear, enable, and a terminal-count flag at WIDTH-1, instantiated once.
- The FSM and capture registers stay in the top.

Test Plan:
1. Reset with Resetn=0 mid-clock -> all outputs 0 immediately; req_ready=1 on the first cycle after release.
2. WIDTH=4, accept req_data=4'b1011, req_fill=0 at edge t -> sr_L=1 at t+1; ser_bit=1,1,0,1 at t+2..t+5; ser_last only at t+5; done at t+6; req_ready at t+7.
3. Back-to-back: req_valid held with 4'hA then 4'h5 -> second accept exactly WIDTH+3=7 cycles after the first; streams 0,1,0,1 then 1,0,1,0.
4. abort at the second SHIFT cycle of 4'hF -> ser_valid low next cycle, done pulses once, IDLE the cycle after, no ser_last seen.
5. req_fill=1 with 4'h0, while checking sr_w -> sr_w=1 throughout SHIFT; stream is 0,0,0,0; the external register reads 4'hF after the word.
6. req_valid pulsed during SHIFT and DONE -> ignored and no capture; sr_R unchanged.
